// File: rtl/envelope_shaper.sv
// ADSR amplitude envelope applied to the oscillator sample stream, stepping on a slow tick.
// Optional: define ENV_RETRIGGER_EN to restart the level from 0 on every ATTACK entry.
module envelope_shaper #(
  parameter int TICK_DIV = 256
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       gate,
  input  logic [7:0] data_in,
  input  logic [7:0] attack_step,
  input  logic [7:0] decay_step,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_step,
  output logic [7:0] data_out,
  output logic [7:0] env_level,
  output logic [2:0] env_state,
  output logic       active
);

  localparam int            CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

`ifdef ENV_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } env_state_t;

  env_state_t    state_q, state_d;
  logic [7:0]    level_q, level_d;
  logic [CW-1:0] tick_cnt_q;
  logic          gate_q;
  logic          tick, rise, fall;
  logic [8:0]    attack_sum, decay_floor;
  logic [15:0]   scaled;

  assign tick        = (tick_cnt_q == TICK_MAX);
  assign rise        = gate & ~gate_q;
  assign fall        = ~gate & gate_q;
  assign attack_sum  = {1'b0, level_q} + {1'b0, attack_step};
  assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_step};
  // Rounds up so a full-scale sample at full level stays at 255.
  assign scaled      = (16'(data_in) * 16'(level_q)) + 16'd255;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt_q <= '0;
      gate_q     <= 1'b0;
      data_out   <= 8'd0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      gate_q     <= gate;
      data_out   <= scaled[15:8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      level_q <= 8'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Gate edges take priority; a cycle with a gate-driven transition applies no level step.
  // NOTE: defaults first so every path assigns state_d/level_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_ATTACK;
          if (RETRIGGER) level_d = 8'd0;
        end
      end
      S_ATTACK: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          if (attack_sum >= 9'd255) begin
            level_d = 8'd255;
            state_d = S_DECAY;
          end else begin
            level_d = attack_sum[7:0];
          end
        end
      end
      S_DECAY: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          if ({1'b0, level_q} <= decay_floor) begin
            level_d = sustain_level;
            state_d = S_SUSTAIN;
          end else begin
            level_d = level_q - decay_step;
          end
        end
      end
      S_SUSTAIN: begin
        if (fall) state_d = S_RELEASE;
        else      level_d = sustain_level;
      end
      S_RELEASE: begin
        if (rise) begin
          state_d = S_ATTACK;
          if (RETRIGGER) level_d = 8'd0;
        end else if (tick) begin
          if (level_q <= release_step) begin
            level_d = 8'd0;
            state_d = S_IDLE;
          end else begin
            level_d = level_q - release_step;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        level_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    env_state = state_q;
    env_level = level_q;
    active    = (state_q != S_IDLE);
  end

endmodule
